debug_instr_seq: RTL and testbench

//  Parametrised instruction sequencer driving the CPU top's debug instruction port (instr_debug_i).

---
 rtl/debug_seq_pkg.sv | 12 +
 rtl/debug_instr_seq_if.sv | 32 +++
 rtl/seq_prog_mem.sv | 26 ++
 rtl/debug_instr_seq.sv | 166 ++++++++++++++++
 tb/tb_debug_instr_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/debug_seq_pkg.sv
// Shared types and constants for the debug instruction sequencer.
package debug_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam logic [31:0] SEQ_NOP = 32'h0000_0000;

endpackage

// File: rtl/debug_instr_seq_if.sv
// Host-side bus of the debug instruction sequencer: program load, replay control and CPU-facing outputs.
interface debug_instr_seq_if #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned DEPTH     = 16
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                 wr_en_i;
    logic [DATAWIDTH-1:0] wr_data_i;
    logic                 clear_i;
    logic                 start_i;
    logic                 stop_i;
    logic                 loop_i;
    logic                 stall_i;
    logic [DATAWIDTH-1:0] instr_o;
    logic                 instr_valid_o;
    logic                 busy_o;
    logic                 done_o;
    logic [CW-1:0]        count_o;
    logic                 full_o;

    modport master (
        output wr_en_i, wr_data_i, clear_i, start_i, stop_i, loop_i, stall_i,
        input  instr_o, instr_valid_o, busy_o, done_o, count_o, full_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, clear_i, start_i, stop_i, loop_i, stall_i,
        output instr_o, instr_valid_o, busy_o, done_o, count_o, full_o
    );

endinterface

// File: rtl/seq_prog_mem.sv
// Program storage: DEPTH x DATAWIDTH register array, one synchronous write port, one combinational read port.
module seq_prog_mem #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [DATAWIDTH-1:0] rdata_o
);

    // Contents deliberately survive reset; only the fill count is cleared.
    logic [DATAWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/debug_instr_seq.sv
// Debug instruction sequencer: loads a small program and replays it one word per cycle (one-shot or loop).
// Optional SEQ_LOOP_CNT_EN adds a saturating wrap counter on loops_o.
module debug_instr_seq
    import debug_seq_pkg::*;
#(
    parameter int unsigned          DATAWIDTH = 32,
    parameter int unsigned          DEPTH     = 16,
    parameter logic [DATAWIDTH-1:0] NOP_INSTR = DATAWIDTH'(SEQ_NOP)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    debug_instr_seq_if.slave bus
`ifdef SEQ_LOOP_CNT_EN
    ,
    output logic [15:0]     loops_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    seq_state_e           state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 loop_q, loop_d;
    logic                 last_q, last_d;
    logic [DATAWIDTH-1:0] instr_q, instr_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
`ifdef SEQ_LOOP_CNT_EN
    logic [15:0]          loops_q, loops_d;
`endif

    logic                 mem_we;
    logic [DATAWIDTH-1:0] mem_rdata;
    logic                 full;

    assign full = (count_q == CW'(DEPTH));

    seq_prog_mem #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (bus.wr_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        loop_d   = loop_q;
        last_d   = last_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        mem_we   = 1'b0;
`ifdef SEQ_LOOP_CNT_EN
        loops_d  = loops_q;
`endif
        unique case (state_q)
            IDLE: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                if (bus.start_i) begin
`ifdef SEQ_LOOP_CNT_EN
                    loops_d = '0;
`endif
                    if (count_q != '0) begin
                        state_d  = RUN;
                        rd_ptr_d = '0;
                        loop_d   = bus.loop_i;
                        last_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (bus.clear_i) begin
                    count_d = '0;
                end else if (bus.wr_en_i && !full) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            RUN: begin
                // last_q marks that the final one-shot entry is already on instr_o.
                if (bus.stop_i || (!bus.stall_i && last_q)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!bus.stall_i) begin
                    instr_d = mem_rdata;
                    valid_d = 1'b1;
                    if (CW'(rd_ptr_q) == count_q - CW'(1)) begin
                        if (loop_q) begin
                            rd_ptr_d = '0;
`ifdef SEQ_LOOP_CNT_EN
                            if (loops_q != 16'hFFFF) begin
                                loops_d = loops_q + 16'd1;
                            end
`endif
                        end else begin
                            last_d = 1'b1;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            loop_q   <= 1'b0;
            last_q   <= 1'b0;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_LOOP_CNT_EN
            loops_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            loop_q   <= loop_d;
            last_q   <= last_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
`ifdef SEQ_LOOP_CNT_EN
            loops_q  <= loops_d;
`endif
        end
    end

    assign bus.instr_o       = instr_q;
    assign bus.instr_valid_o = valid_q;
    assign bus.busy_o        = (state_q == RUN);
    assign bus.done_o        = done_q;
    assign bus.count_o       = count_q;
    assign bus.full_o        = full;
`ifdef SEQ_LOOP_CNT_EN
    assign loops_o           = loops_q;
`endif

endmodule

// File: tb/tb_debug_instr_seq.sv
// Directed bench for debug_instr_seq (DEPTH=4): load, one-shot, loop, stall, full/clear, stop and async reset.
module tb_debug_instr_seq;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    localparam logic [31:0] W_ADD  = 32'h0020_81B3;
    localparam logic [31:0] W_SUB  = 32'h4020_81B3;
    localparam logic [31:0] W_ADDI = 32'h0450_0093;
    localparam logic [31:0] W_D0   = 32'hA000_0001;
    localparam logic [31:0] W_D1   = 32'hA000_0002;
    localparam logic [31:0] W_D2   = 32'hA000_0003;
    localparam logic [31:0] W_D3   = 32'hA000_0004;
    localparam logic [31:0] W_D4   = 32'hA000_0005;
    localparam logic [31:0] W_X    = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   nerr = 0;
    int   nchk = 0;
`ifdef SEQ_LOOP_CNT_EN
    logic [15:0] loops;
`endif

    always #5 clk = ~clk;

    debug_instr_seq_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) bus ();

    debug_instr_seq #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef SEQ_LOOP_CNT_EN
        ,
        .loops_o (loops)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic b, input logic d);
        chk({tag, ".valid"}, 64'(bus.instr_valid_o), 64'(v));
        chk({tag, ".instr"}, 64'(bus.instr_o), 64'(ins));
        chk({tag, ".busy"},  64'(bus.busy_o), 64'(b));
        chk({tag, ".done"},  64'(bus.done_o), 64'(d));
    endtask

    task automatic load(input logic [31:0] w);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = w;
        tick();
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
    endtask

    task automatic do_start(input logic lp);
        bus.start_i = 1'b1;
        bus.loop_i  = lp;
        tick();
        bus.start_i = 1'b0;
        bus.loop_i  = 1'b0;
    endtask

    initial begin
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = '0;
        bus.clear_i   = 1'b0;
        bus.start_i   = 1'b0;
        bus.stop_i    = 1'b0;
        bus.loop_i    = 1'b0;
        bus.stall_i   = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk_out("rst", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst.count", 64'(bus.count_o), 64'd0);
        chk("rst.full",  64'(bus.full_o),  64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // 1) one-shot replay of three words
        load(W_ADD);
        load(W_SUB);
        load(W_ADDI);
        chk("t1.count", 64'(bus.count_o), 64'd3);
        chk("t1.full",  64'(bus.full_o),  64'd0);
        do_start(1'b0);
        chk_out("t1.lat", 1'b0, 32'h0, 1'b1, 1'b0);
        tick(); chk_out("t1.e0", 1'b1, W_ADD,  1'b1, 1'b0);
        tick(); chk_out("t1.e1", 1'b1, W_SUB,  1'b1, 1'b0);
        tick(); chk_out("t1.e2", 1'b1, W_ADDI, 1'b1, 1'b0);
        tick(); chk_out("t1.done", 1'b0, 32'h0, 1'b0, 1'b1);
        tick(); chk_out("t1.idle", 1'b0, 32'h0, 1'b0, 1'b0);

        // 2) loop replay of two words, 7 cycles, then stop
        do_clear();
        chk("t2.clr", 64'(bus.count_o), 64'd0);
        load(W_ADD);
        load(W_SUB);
        do_start(1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_out($sformatf("t2.c%0d", i), 1'b1, (i % 2 == 0) ? W_ADD : W_SUB, 1'b1, 1'b0);
        end
`ifdef SEQ_LOOP_CNT_EN
        chk("t2.loops", 64'(loops), 64'd3);
`endif
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        chk_out("t2.stop", 1'b0, 32'h0, 1'b0, 1'b1);
        tick(); chk_out("t2.idle", 1'b0, 32'h0, 1'b0, 1'b0);

        // 3) stall on the second entry for two cycles
        do_clear();
        load(W_ADD);
        load(W_SUB);
        load(W_ADDI);
        do_start(1'b0);
        tick(); chk_out("t3.e0", 1'b1, W_ADD, 1'b1, 1'b0);
        tick(); chk_out("t3.e1", 1'b1, W_SUB, 1'b1, 1'b0);
        bus.stall_i = 1'b1;
        tick(); chk_out("t3.h1", 1'b1, W_SUB, 1'b1, 1'b0);
        tick(); chk_out("t3.h2", 1'b1, W_SUB, 1'b1, 1'b0);
        bus.stall_i = 1'b0;
        tick(); chk_out("t3.e2", 1'b1, W_ADDI, 1'b1, 1'b0);
        tick(); chk_out("t3.done", 1'b0, 32'h0, 1'b0, 1'b1);
        tick();

        // 4) overfill, replay the kept words, then start on an empty program
        do_clear();
        load(W_D0);
        load(W_D1);
        load(W_D2);
        load(W_D3);
        chk("t4.full4", 64'(bus.full_o), 64'd1);
        load(W_D4);
        chk("t4.count", 64'(bus.count_o), 64'(DEPTH));
        chk("t4.full",  64'(bus.full_o),  64'd1);
        do_start(1'b0);
        tick(); chk_out("t4.e0", 1'b1, W_D0, 1'b1, 1'b0);
        tick(); chk_out("t4.e1", 1'b1, W_D1, 1'b1, 1'b0);
        tick(); chk_out("t4.e2", 1'b1, W_D2, 1'b1, 1'b0);
        tick(); chk_out("t4.e3", 1'b1, W_D3, 1'b1, 1'b0);
        tick(); chk_out("t4.done", 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = W_X;
        do_clear();
        bus.wr_en_i   = 1'b0;
        chk("t4.clrwins", 64'(bus.count_o), 64'd0);
        chk("t4.clrfull", 64'(bus.full_o),  64'd0);
        do_start(1'b0);
        chk_out("t4.empty", 1'b0, 32'h0, 1'b0, 1'b1);
        tick(); chk_out("t4.eidle", 1'b0, 32'h0, 1'b0, 1'b0);

        // 5) writes ignored during RUN, stop at entry 1
        load(W_ADD);
        load(W_SUB);
        load(W_ADDI);
        do_start(1'b1);
        tick(); chk_out("t5.e0", 1'b1, W_ADD, 1'b1, 1'b0);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = W_X;
        tick(); chk_out("t5.e1", 1'b1, W_SUB, 1'b1, 1'b0);
        chk("t5.cnt_run", 64'(bus.count_o), 64'd3);
        bus.stop_i  = 1'b1;
        bus.stall_i = 1'b1;
        tick();
        bus.stop_i  = 1'b0;
        bus.stall_i = 1'b0;
        chk_out("t5.stop", 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5.cnt_done", 64'(bus.count_o), 64'd3);
        bus.wr_en_i = 1'b0;
        tick(); chk_out("t5.idle", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t5.cnt_idle", 64'(bus.count_o), 64'd3);

        // 6) asynchronous reset in the middle of RUN
        do_start(1'b1);
        tick(); chk_out("t6.e0", 1'b1, W_ADD, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk_out("t6.rst", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6.count", 64'(bus.count_o), 64'd0);
        chk("t6.full",  64'(bus.full_o),  64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk_out("t6.after", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6.count2", 64'(bus.count_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
